systolic_result_collector: RTL

- Downstream consumer of the 2x2 systolic matmul core's output bus (`uo_out`/`uio_out`/`uio_oe`).
- Detects the two-beat result burst and reverses the nibble-split packing into four 8-bit C elements.
- Buffers whole result matrices in a small FIFO.
- Streams the elements row-major over a valid/ready interface to the next stage (host readback or accumulator).

---
 rtl/systolic_result_collector_pkg.sv | 27 ++
 rtl/systolic_result_collector_if.sv | 23 ++
 rtl/systolic_result_collector_fifo.sv | 47 ++++
 rtl/systolic_result_collector.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/systolic_result_collector_pkg.sv
// Shared types and constants for the systolic result collector.
// RESULT_CHECKSUM_EN adds a fifth per-matrix checksum element.
package systolic_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BEAT2,
        TAIL
    } capState_e;

    localparam logic [7:0] OE_ACTIVE = 8'hFF;

`ifdef RESULT_CHECKSUM_EN
    localparam int ELEMS = 5;
`else
    localparam int ELEMS = 4;
`endif

    localparam int ENTRY_W = 8 * ELEMS;
    localparam int IDX_W   = $clog2(ELEMS);

    // Undo the core's nibble split: returns {first element, second element}.
    function automatic logic [15:0] unpackBeat(input logic [7:0] uo, input logic [7:0] uio);
        return {uio[7:4], uo[7:4], uio[3:0], uo[3:0]};
    endfunction

endpackage

// File: rtl/systolic_result_collector_if.sv
// Core result bus in, element stream out; master is the collector side.
interface systolic_result_collector_if;

    logic [7:0] mm_uo;
    logic [7:0] mm_uio;
    logic [7:0] mm_oe;
    logic [7:0] el_data;
    logic [1:0] el_idx;
    logic       el_last;
    logic       el_valid;
    logic       el_ready;

    modport master (
        input  mm_uo, mm_uio, mm_oe, el_ready,
        output el_data, el_idx, el_last, el_valid
    );

    modport slave (
        output mm_uo, mm_uio, mm_oe, el_ready,
        input  el_data, el_idx, el_last, el_valid
    );

endinterface

// File: rtl/systolic_result_collector_fifo.sv
// Generic synchronous FIFO; a push while full is taken when a pop happens in the same cycle.
module result_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             empty_o,
    output logic             full_o,
    output logic             accept_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wrPtr_q;
    logic [AW:0]      rdPtr_q;
    logic             doPush;
    logic             doPop;

    assign empty_o  = (wrPtr_q == rdPtr_q);
    assign full_o   = (wrPtr_q[AW] != rdPtr_q[AW]) && (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
    assign doPop    = pop_i && !empty_o;
    assign doPush   = push_i && (!full_o || doPop);
    assign accept_o = doPush;
    assign rdata_o  = mem_q[rdPtr_q[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
        end else begin
            if (doPush) wrPtr_q <= wrPtr_q + PTR_ONE;
            if (doPop)  rdPtr_q <= rdPtr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (doPush) mem_q[wrPtr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/systolic_result_collector.sv
// Captures the core's two-beat result burst, buffers whole 2x2 matrices, streams elements row-major.
// RESULT_CHECKSUM_EN appends a checksum element after C11.
module systolic_result_collector
    import systolic_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    systolic_result_collector_if.master bus,
    input  logic                        clr,
    output logic                        full,
    output logic                        overflow,
    output logic                        proto_err,
    output logic [7:0]                  mat_count
);

    capState_e          state_q;
    logic [15:0]        stage_q;
    logic [IDX_W-1:0]   drainIdx_q;
    logic               overflow_q;
    logic               protoErr_q;
    logic [7:0]         matCount_q;

    logic               beatOn;
    logic [15:0]        beatEls;
    logic               pushReq;
    logic               pushAcc;
    logic               popHead;
    logic               fifoEmpty;
    logic               fifoFull;
    logic               elValid;
    logic               handshake;
    logic               isLast;
    logic [31:0]        matrix;
    logic [ENTRY_W-1:0] entryIn;
    logic [ENTRY_W-1:0] headEntry;
    logic [7:0]         headEls [2**IDX_W];

    assign beatOn  = (bus.mm_oe == OE_ACTIVE);
    assign beatEls = unpackBeat(bus.mm_uo, bus.mm_uio);
    assign pushReq = (state_q == BEAT2) && beatOn;

    // Entry byte k holds element k: C00, C01, C10, C11 (, checksum).
    assign matrix = {beatEls[7:0], beatEls[15:8], stage_q[7:0], stage_q[15:8]};

`ifdef RESULT_CHECKSUM_EN
    logic [7:0] checksum;
    assign checksum = stage_q[15:8] + stage_q[7:0] + beatEls[15:8] + beatEls[7:0];
    assign entryIn  = {checksum, matrix};
`else
    assign entryIn  = matrix;
`endif

    result_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push_i   (pushReq),
        .pop_i    (popHead),
        .wdata_i  (entryIn),
        .rdata_o  (headEntry),
        .empty_o  (fifoEmpty),
        .full_o   (fifoFull),
        .accept_o (pushAcc)
    );

    for (genvar i = 0; i < 2**IDX_W; i++) begin : g_els
        if (i < ELEMS) begin : g_used
            assign headEls[i] = headEntry[8*i +: 8];
        end else begin : g_unused
            assign headEls[i] = 8'h00;
        end
    end

    assign elValid   = !fifoEmpty;
    assign isLast    = (drainIdx_q == IDX_W'(ELEMS - 1));
    assign handshake = elValid && bus.el_ready;
    assign popHead   = handshake && isLast;

    // The checksum slot (index 4) reports idx 0 through the low two bits.
    assign bus.el_valid = elValid;
    assign bus.el_data  = elValid ? headEls[drainIdx_q] : 8'h00;
    assign bus.el_idx   = elValid ? drainIdx_q[1:0] : 2'd0;
    assign bus.el_last  = elValid && isLast;

    assign full      = fifoFull;
    assign overflow  = overflow_q;
    assign proto_err = protoErr_q;
    assign mat_count = matCount_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            stage_q    <= '0;
            protoErr_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (beatOn) begin
                        stage_q <= beatEls;
                        state_q <= BEAT2;
                    end
                end
                BEAT2: begin
                    if (beatOn) begin
                        state_q <= TAIL;
                    end else begin
                        protoErr_q <= 1'b1;
                        state_q    <= IDLE;
                    end
                end
                TAIL: begin
                    if (beatOn) protoErr_q <= 1'b1;
                    else        state_q    <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
            if (clr) protoErr_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q <= 1'b0;
            matCount_q <= 8'd0;
        end else if (clr) begin
            overflow_q <= 1'b0;
            matCount_q <= 8'd0;
        end else begin
            if (pushReq && !pushAcc) overflow_q <= 1'b1;
            if (pushAcc)             matCount_q <= matCount_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drainIdx_q <= '0;
        end else if (handshake) begin
            drainIdx_q <= isLast ? '0 : drainIdx_q + IDX_W'(1);
        end
    end

endmodule
